// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : hazard requests in, pipeline-register controls out
// Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             stall_lu;
   logic             jal_id;
   logic             br_taken_ex;
   logic             mem_req;
   logic             mem_ack;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             if_id_we;
   logic             if_id_flush;
   logic             id_ex_we;
   logic             id_ex_flush;
   logic             ex_mem_we;
   logic             mem_wb_bubble;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output stall_lu, jal_id, br_taken_ex, mem_req, mem_ack,
      input  pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
             ex_mem_we, mem_wb_bubble, mem_err, stall_cycles, flush_events
   );

   modport slave (
      input  stall_lu, jal_id, br_taken_ex, mem_req, mem_ack,
      output pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
             ex_mem_we, mem_wb_bubble, mem_err, stall_cycles, flush_events
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush sequencer with memory-wait timeout and stats
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  wire               clk,
   input  wire               rstn,
   pipe_hazard_ctrl_if.slave hz_bus
);
   localparam logic [1:0] c_ST_RUN   = 2'd0;
   localparam logic [1:0] c_ST_MWAIT = 2'd1;
   localparam logic [1:0] c_ST_MERR  = 2'd2;
   localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

   logic       w_pc_we, w_if_id_we, w_if_id_flush, w_id_ex_we, w_id_ex_flush;
   logic       w_ex_mem_we, w_mem_wb_bubble, w_mem_err, w_resolve;
   logic [1:0] w_pc_sel;

   always_comb begin
      // Freeze values are the default; w_resolve upgrades to the redirect/stall decision.
      w_pc_we         = 1'b0;
      w_if_id_we      = 1'b0;
      w_id_ex_we      = 1'b0;
      w_ex_mem_we     = 1'b0;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_mem_wb_bubble = 1'b1;
      w_pc_sel        = 2'b00;
      w_mem_err       = 1'b0;
      w_resolve       = 1'b0;
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;

      if (!rstn) begin
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
         state_d       = c_ST_RUN;
         wait_cnt_d    = 8'd0;
      end else begin
         case (state_q)
            c_ST_RUN: begin
               if (hz_bus.mem_req && !hz_bus.mem_ack) begin
                  wait_cnt_d = 8'd1;
                  state_d    = c_ST_MWAIT;
               end else begin
                  w_resolve = 1'b1;
               end
            end
            c_ST_MWAIT: begin
               if (hz_bus.mem_ack) begin
                  w_resolve = 1'b1;
                  state_d   = c_ST_RUN;
               end else if (wait_cnt_q == c_MAX_WAIT) begin
                  state_d = c_ST_MERR;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            c_ST_MERR: begin
               w_resolve = 1'b1;
               w_mem_err = 1'b1;
               state_d   = c_ST_RUN;
            end
            default: state_d = c_ST_RUN;
         endcase
      end

      if (w_resolve) begin
         // The timed-out access must not write back, so MERR keeps the bubble.
         w_mem_wb_bubble = (state_q == c_ST_MERR);
         w_ex_mem_we     = 1'b1;
         w_id_ex_we      = 1'b1;
         if (hz_bus.br_taken_ex) begin
            w_pc_sel      = 2'b10;
            w_pc_we       = 1'b1;
            w_if_id_we    = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
         end else if (hz_bus.jal_id) begin
            w_pc_sel      = 2'b01;
            w_pc_we       = 1'b1;
            w_if_id_we    = 1'b1;
            w_if_id_flush = 1'b1;
         end else if (hz_bus.stall_lu) begin
            w_id_ex_flush = 1'b1;
         end else begin
            w_pc_we    = 1'b1;
            w_if_id_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= c_ST_RUN;
         wait_cnt_q     <= 8'd0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!w_pc_we && !(&stall_cycles_q)) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
         end
         if (w_if_id_flush && !(&flush_events_q)) begin
            flush_events_q <= flush_events_q + 1'b1;
         end
      end
   end

   assign hz_bus.pc_we         = w_pc_we;
   assign hz_bus.pc_sel        = w_pc_sel;
   assign hz_bus.if_id_we      = w_if_id_we;
   assign hz_bus.if_id_flush   = w_if_id_flush;
   assign hz_bus.id_ex_we      = w_id_ex_we;
   assign hz_bus.id_ex_flush   = w_id_ex_flush;
   assign hz_bus.ex_mem_we     = w_ex_mem_we;
   assign hz_bus.mem_wb_bubble = w_mem_wb_bubble;
   assign hz_bus.mem_err       = w_mem_err;
   assign hz_bus.stall_cycles  = stall_cycles_q;
   assign hz_bus.flush_events  = flush_events_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed checks on a default instance (a) and a
// MAX_WAIT=3 / CNT_W=4 instance (b) driven with identical inputs. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   failures = 0;

   pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  ifb ();

   pipe_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) u_dut_a (
      .clk    (clk),
      .rstn   (rstn),
      .hz_bus (ifa)
   );

   pipe_hazard_ctrl #(.MAX_WAIT(3), .CNT_W(4)) u_dut_b (
      .clk    (clk),
      .rstn   (rstn),
      .hz_bus (ifb)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic st, input logic jal, input logic br,
                         input logic req, input logic ack);
      ifa.stall_lu = st;  ifa.jal_id = jal; ifa.br_taken_ex = br;
      ifa.mem_req  = req; ifa.mem_ack = ack;
      ifb.stall_lu = st;  ifb.jal_id = jal; ifb.br_taken_ex = br;
      ifb.mem_req  = req; ifb.mem_ack = ack;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      set_in(0, 0, 0, 0, 0);
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      // 1. reset with every input high
      rstn = 1'b0;
      set_in(1, 1, 1, 1, 1);
      tick(); tick(); tick();
      chk("rst_pc_we",       ifa.pc_we, 0);
      chk("rst_if_id_we",    ifa.if_id_we, 0);
      chk("rst_if_id_flush", ifa.if_id_flush, 1);
      chk("rst_id_ex_flush", ifa.id_ex_flush, 1);
      chk("rst_bubble",      ifa.mem_wb_bubble, 1);
      chk("rst_pc_sel",      ifa.pc_sel, 0);
      chk("rst_mem_err",     ifb.mem_err, 0);
      chk("rst_stall_cnt",   ifa.stall_cycles, 0);
      chk("rst_flush_cnt",   ifa.flush_events, 0);
      rstn = 1'b1;
      set_in(0, 0, 0, 0, 0);
      chk("run_pc_we",     ifa.pc_we, 1);
      chk("run_if_id_we",  ifa.if_id_we, 1);
      chk("run_id_ex_we",  ifa.id_ex_we, 1);
      chk("run_ex_mem_we", ifa.ex_mem_we, 1);
      chk("run_bubble",    ifa.mem_wb_bubble, 0);
      chk("run_flushes",   {ifa.if_id_flush, ifa.id_ex_flush}, 0);

      // 2. load-use stall for one cycle
      tick();
      set_in(1, 0, 0, 0, 0);
      chk("lu_pc_we",       ifa.pc_we, 0);
      chk("lu_if_id_we",    ifa.if_id_we, 0);
      chk("lu_id_ex_flush", ifa.id_ex_flush, 1);
      chk("lu_id_ex_we",    ifa.id_ex_we, 1);
      chk("lu_if_id_flush", ifa.if_id_flush, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      chk("lu_stall_cnt", ifa.stall_cycles, 1);
      chk("lu_after_pc_we", ifa.pc_we, 1);
      chk("lu_after_if_id_we", ifa.if_id_we, 1);

      // 3. branch beats JAL beats load-use; then JAL alone
      do_reset();
      set_in(1, 1, 1, 0, 0);
      chk("pri_pc_sel",      ifa.pc_sel, 2'b10);
      chk("pri_pc_we",       ifa.pc_we, 1);
      chk("pri_if_id_flush", ifa.if_id_flush, 1);
      chk("pri_id_ex_flush", ifa.id_ex_flush, 1);
      tick();
      set_in(0, 1, 0, 0, 0);
      chk("pri_flush_cnt", ifa.flush_events, 1);
      chk("pri_stall_cnt", ifa.stall_cycles, 0);
      chk("jal_pc_sel",      ifa.pc_sel, 2'b01);
      chk("jal_id_ex_flush", ifa.id_ex_flush, 0);
      chk("jal_if_id_flush", ifa.if_id_flush, 1);
      tick();
      set_in(0, 0, 0, 0, 0);
      chk("jal_flush_cnt", ifa.flush_events, 2);

      // 4. memory wait: 4 cycles without ack, then ack (instance a)
      do_reset();
      set_in(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         chk("mw_pc_we",  ifa.pc_we, 0);
         chk("mw_bubble", ifa.mem_wb_bubble, 1);
         tick();
      end
      set_in(1, 0, 0, 1, 1);
      chk("mw_ack_pc_we",  ifa.pc_we, 0);
      chk("mw_ack_id_ex_flush", ifa.id_ex_flush, 1);
      chk("mw_ack_bubble", ifa.mem_wb_bubble, 0);
      tick();
      set_in(0, 0, 0, 0, 0);
      chk("mw_stall_cnt",  ifa.stall_cycles, 5);
      chk("mw_run_pc_we",  ifa.pc_we, 1);
      chk("mw_run_bubble", ifa.mem_wb_bubble, 0);

      // 5. timeout on instance b (MAX_WAIT=3)
      do_reset();
      set_in(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         chk("to_frozen_pc_we", ifb.pc_we, 0);
         chk("to_frozen_err",   ifb.mem_err, 0);
         tick();
      end
      chk("to_err",    ifb.mem_err, 1);
      chk("to_bubble", ifb.mem_wb_bubble, 1);
      chk("to_pc_we",  ifb.pc_we, 1);
      set_in(0, 0, 0, 1, 1);
      chk("to_late_ack_err", ifb.mem_err, 1);
      set_in(0, 0, 0, 1, 0);
      tick();
      chk("to_rewait_err",   ifb.mem_err, 0);
      chk("to_rewait_pc_we", ifb.pc_we, 0);
      chk("to_stall_cnt",    ifb.stall_cycles, 4);

      // 6. reset during the second wait cycle, then counter saturation
      do_reset();
      set_in(0, 0, 0, 1, 0);
      tick();
      rstn = 1'b0;
      #1;
      chk("rw_err",   ifb.mem_err, 0);
      chk("rw_pc_we", ifb.pc_we, 0);
      tick();
      rstn = 1'b1;
      set_in(0, 0, 0, 0, 0);
      chk("rw_stall_cnt", ifb.stall_cycles, 0);
      chk("rw_run_pc_we", ifb.pc_we, 1);
      for (int i = 0; i < 4; i++) begin
         chk("rw_no_err", ifb.mem_err, 0);
         tick();
      end
      set_in(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      set_in(0, 0, 0, 0, 0);
      chk("sat_b_stall_cnt", ifb.stall_cycles, 15);
      chk("sat_a_stall_cnt", ifa.stall_cycles, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the load-use stall request from the forwarding unit, the JAL redirect from ID, the branch/JALR redirect from EX, and the data-memory wait handshake from MEM. From these it drives every pipeline-register write enable, flush, the PC source select, and saturating stall/flush statistics. It sits beside the forwarding unit and feeds the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
MAX_WAIT, 15, max cycles spent waiting for mem_ack before timeout (1..255)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  single clock, all state updates on rising edge
rstn  in  1  synchronous, active-low reset
stall_lu  in  1  load-use stall request from forwarding unit (ID stage)
jal_id  in  1  JAL decoded in ID; target available in ID
br_taken_ex  in  1  branch taken or JALR resolved in EX
mem_req  in  1  EX/MEM holds a valid load/store this cycle
mem_ack  in  1  data memory completes the access this cycle
pc_we  out  1  PC register write enable
pc_sel  out  2  00 PC+4, 01 ID target (JAL), 10 EX target (branch/JALR)
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_we  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_we  out  1  EX/MEM write enable
mem_wb_bubble  out  1  MEM/WB loads bubble (RegWrite=0)
mem_err  out  1  one-cycle pulse on memory timeout
stall_cycles  out  CNT_W  count of cycles with pc_we=0
flush_events  out  CNT_W  count of redirect cycles

Behaviour:
- State: FSM {RUN, MWAIT, MERR}; wait_cnt (8 bit); two counters. Outputs are combinational from state and current inputs (Mealy). The counters are registered.
- rstn=0 at a clock edge: state<=RUN, wait_cnt<=0, counters<=0.
- While rstn=0, outputs are forced: pc_we=if_id_we=id_ex_we=ex_mem_we=0; if_id_flush=id_ex_flush=mem_wb_bubble=1; pc_sel=00; mem_err=0.
- Freeze outputs: pc_we=if_id_we=id_ex_we=ex_mem_we=0, both flushes 0, mem_wb_bubble=1, pc_sel=00.
- RUN, mem_req=1 and mem_ack=0: apply freeze; wait_cnt<=1; next MWAIT. Redirect and stall inputs are ignored this cycle.
- RUN, otherwise (includes mem_req=1 with mem_ack=1, which has zero wait): mem_wb_bubble=0. Priority is br_taken_ex > jal_id > stall_lu > normal:
  - br_taken_ex: pc_sel=10, pc_we=1, if_id_flush=1, id_ex_flush=1, id_ex_we=1, if_id_we=1, ex_mem_we=1. Counts as a flush event.
  - jal_id: pc_sel=01, pc_we=1, if_id_flush=1, if_id_we=1, id_ex_we=1, ex_mem_we=1. Counts as a flush event.
  - stall_lu: pc_we=0, if_id_we=0, id_ex_flush=1, id_ex_we=1, ex_mem_we=1. Counts as a stall cycle.
  - normal: all write enables 1, flushes 0, pc_sel=00.
- MWAIT, mem_ack=1: behave exactly like the RUN "otherwise" case this cycle, including redirect/stall priority; next RUN.
- MWAIT, mem_ack=0: apply freeze. If wait_cnt==MAX_WAIT, next MERR; else wait_cnt<=wait_cnt+1.
- MERR: mem_err=1 for this cycle only. Outputs are the RUN "otherwise" case except mem_wb_bubble=1, which squashes the failed access's writeback. Next RUN. A late mem_ack in MERR is ignored.
- stall_cycles: +1 every cycle with rstn=1 and pc_we=0, from any cause. Saturates at 2^CNT_W-1.
- flush_events: +1 every cycle with rstn=1 and if_id_flush=1. Saturates.
- Reset mid-MWAIT: the wait is abandoned and no mem_err is issued.
- Timeout window: MAX_WAIT freeze cycles after the entry cycle, i.e. MAX_WAIT+1 frozen cycles total, then MERR.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles with all inputs 1 -> pc_we=0, flushes=1, stall_cycles=0, flush_events=0. Release -> no inputs active gives all write enables 1.
2. Load-use: stall_lu=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle; stall_cycles=1; next cycle all write enables 1.
3. Priority: br_taken_ex=1, jal_id=1, stall_lu=1 together -> pc_sel=10, pc_we=1, if_id_flush=id_ex_flush=1; flush_events=1, stall_cycles=0.
4. Memory wait: mem_req=1, mem_ack low for 4 cycles then high -> 4 frozen cycles with mem_wb_bubble=1. Ack cycle: normal enables, mem_wb_bubble=0. stall_cycles=4, state back to RUN.
5. Timeout with MAX_WAIT=3: mem_req=1, mem_ack=0 forever -> 4 frozen cycles, then one cycle with mem_err=1, mem_wb_bubble=1, pc_we=1. If mem_req is still 1 with mem_ack=0, a new wait begins.
6. Reset in MWAIT and saturation: rstn=0 during the 2nd wait cycle -> no mem_err, counters 0. With CNT_W=4, 20 stall cycles -> stall_cycles holds at 15.
